// File: rtl/pipe_stage.sv
// Valid/ready pipeline register stage with an optional two-entry skid buffer.
// The main entry drives out_valid/out_data straight from flops. SKID=1 adds a
// second entry so in_ready can be registered. SKID=0 keeps a single entry with
// a combinational in_ready.
module pipe_stage #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned      SKID   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // State encoding doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_q;
  logic             skid_load;
  logic             out_valid_q;
  logic             xfer_in;
  logic             xfer_out;

  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;

  // Next-state and main-entry payload selection; clear overrides every transfer.
  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_load = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_nxt = ST_ONE;
          main_nxt  = in_data;
        end
      end
      ST_ONE: begin
        if (xfer_in && xfer_out) begin
          main_nxt = in_data;
        end else if (xfer_in) begin
          // Only reachable with a skid entry; SKID=0 blocks input while stalled.
          if (SKID != 0) begin
            state_nxt = ST_FULL;
            skid_load = 1'b1;
          end
        end else if (xfer_out) begin
          state_nxt = ST_EMPTY;
          main_nxt  = BUBBLE;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          state_nxt = ST_ONE;
          main_nxt  = skid_q;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
        main_nxt  = BUBBLE;
      end
    endcase
    if (clear) begin
      state_nxt = ST_EMPTY;
      main_nxt  = BUBBLE;
      skid_load = 1'b0;
    end
  end

  // State, main entry and out_valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      main_q      <= main_nxt;
      out_valid_q <= (state_nxt != ST_EMPTY);
    end
  end

  // Skid entry is written only when the stage becomes full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '0;
    end else if (skid_load) begin
      skid_q <= in_data;
    end
  end

  if (SKID != 0) begin : g_skid
    logic in_ready_q;

    // Registered ready: accept unless the next state is FULL.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= (state_nxt != ST_FULL);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign in_ready = ~out_valid_q | out_ready;
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: a SKID=1 32-bit instance and a SKID=0
// 16-bit instance with a 0xDEAD bubble, driven by directed vectors.
module tb_pipe_stage;

  logic clk;
  logic rst;

  logic        clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_data_a, out_data_a;
  logic [1:0]  count_a;

  logic        clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [15:0] in_data_b, out_data_b;
  logic [1:0]  count_b;

  logic [31:0] exp_a[$];
  logic [15:0] exp_b[$];

  int checks;
  int failures;

  pipe_stage #(.WIDTH(32), .BUBBLE(32'h0), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .clear(clear_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .count(count_a)
  );

  pipe_stage #(.WIDTH(16), .BUBBLE(16'hDEAD), .SKID(0)) u_b (
    .clk(clk), .rst(rst), .clear(clear_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .count(count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle on instance A; the scoreboard learns of accepted entries.
  task automatic cyc_a(input logic v, input logic [31:0] d, input logic ordy, input logic clr);
    in_valid_a = v; in_data_a = d; out_ready_a = ordy; clear_a = clr;
    @(negedge clk);
    if (v && in_ready_a && !clr) exp_a.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic v, input logic [15:0] d, input logic ordy, input logic clr);
    in_valid_b = v; in_data_b = d; out_ready_b = ordy; clear_b = clr;
    @(negedge clk);
    if (v && in_ready_b && !clr) exp_b.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every delivered payload must match the scoreboard head,
  // and an idle output must show the bubble value.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [15:0] eb;
    if (out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon_a: unexpected output %0h", out_data_a);
      end else begin
        ea = exp_a.pop_front();
        check("mon_a_data", out_data_a, ea);
      end
    end else if (!out_valid_a) begin
      check("mon_a_bubble", out_data_a, 32'h0);
    end
    if (out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon_b: unexpected output %0h", out_data_b);
      end else begin
        eb = exp_b.pop_front();
        check("mon_b_data", 32'(out_data_b), 32'(eb));
      end
    end else if (!out_valid_b) begin
      check("mon_b_bubble", 32'(out_data_b), 32'hDEAD);
    end
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    clear_a = 0; in_valid_a = 0; in_data_a = '0; out_ready_a = 0;
    clear_b = 0; in_valid_b = 0; in_data_b = '0; out_ready_b = 0;
    #1 rst = 1'b1;
    #1;
    // Reset takes effect before any clock edge.
    check("rst_a_valid", 32'(out_valid_a), 32'd0);
    check("rst_a_data", out_data_a, 32'h0);
    check("rst_a_count", 32'(count_a), 32'd0);
    check("rst_a_ready", 32'(in_ready_a), 32'd1);
    check("rst_b_valid", 32'(out_valid_b), 32'd0);
    check("rst_b_data", 32'(out_data_b), 32'hDEAD);
    check("rst_b_ready", 32'(in_ready_b), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single transfer through an empty stage.
    cyc_a(1, 32'hA1, 1, 0);
    check("single_valid", 32'(out_valid_a), 32'd1);
    check("single_data", out_data_a, 32'hA1);
    check("single_count", 32'(count_a), 32'd1);
    cyc_a(0, 0, 1, 0);
    check("single_drain_valid", 32'(out_valid_a), 32'd0);
    check("single_drain_data", out_data_a, 32'h0);

    // Back-pressure fills main and skid; third payload stays upstream.
    cyc_a(1, 32'h11, 0, 0);
    check("bp_count1", 32'(count_a), 32'd1);
    check("bp_ready1", 32'(in_ready_a), 32'd1);
    cyc_a(1, 32'h22, 0, 0);
    check("bp_count2", 32'(count_a), 32'd2);
    check("bp_ready2", 32'(in_ready_a), 32'd0);
    cyc_a(1, 32'h33, 0, 0);
    check("bp_count3", 32'(count_a), 32'd2);
    check("bp_hold", out_data_a, 32'h11);
    cyc_a(1, 32'h33, 0, 0);
    check("bp_hold2", out_data_a, 32'h11);
    cyc_a(1, 32'h33, 1, 0);
    check("bp_rel_count", 32'(count_a), 32'd1);
    check("bp_rel_data", out_data_a, 32'h22);
    check("bp_rel_ready", 32'(in_ready_a), 32'd1);
    cyc_a(1, 32'h33, 1, 0);
    check("bp_last_data", out_data_a, 32'h33);
    cyc_a(0, 0, 1, 0);
    check("bp_empty", 32'(count_a), 32'd0);

    // Full throughput streaming.
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1, 32'(i), 1, 0);
      check("tp_count", 32'(count_a), 32'd1);
      check("tp_ready", 32'(in_ready_a), 32'd1);
      check("tp_data", out_data_a, 32'(i));
    end
    cyc_a(0, 0, 1, 0);

    // Clear with two entries held drops them and the offered payload.
    cyc_a(1, 32'hAA, 0, 0);
    cyc_a(1, 32'hBB, 0, 0);
    check("clr_pre_count", 32'(count_a), 32'd2);
    cyc_a(1, 32'h55, 0, 1);
    exp_a.delete();
    check("clr_valid", 32'(out_valid_a), 32'd0);
    check("clr_data", out_data_a, 32'h0);
    check("clr_count", 32'(count_a), 32'd0);
    check("clr_ready", 32'(in_ready_a), 32'd1);
    for (int i = 0; i < 3; i++) cyc_a(0, 0, 1, 0);

    // Asynchronous reset between edges with a full stage.
    cyc_a(1, 32'hC1, 0, 0);
    cyc_a(1, 32'hC2, 0, 0);
    check("ar_pre_count", 32'(count_a), 32'd2);
    #2 rst = 1'b1;
    #1;
    exp_a.delete();
    check("ar_valid", 32'(out_valid_a), 32'd0);
    check("ar_count", 32'(count_a), 32'd0);
    check("ar_ready", 32'(in_ready_a), 32'd1);
    check("ar_data", out_data_a, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc_a(1, 32'h7, 1, 0);
    check("ar_post_valid", 32'(out_valid_a), 32'd1);
    check("ar_post_data", out_data_a, 32'h7);
    cyc_a(0, 0, 1, 0);

    // SKID=0 instance: combinational ready follows out_ready.
    cyc_b(1, 16'h0010, 0, 0);
    check("b_full_ready", 32'(in_ready_b), 32'd0);
    check("b_full_count", 32'(count_b), 32'd1);
    out_ready_b = 1'b1;
    #1;
    check("b_comb_ready", 32'(in_ready_b), 32'd1);
    cyc_b(1, 16'h0042, 1, 0);
    check("b_pass_valid", 32'(out_valid_b), 32'd1);
    check("b_pass_data", 32'(out_data_b), 32'h0042);
    cyc_b(0, 0, 1, 0);
    check("b_idle_data", 32'(out_data_b), 32'hDEAD);
    check("b_idle_count", 32'(count_b), 32'd0);
    cyc_b(1, 16'h0077, 0, 0);
    cyc_b(1, 16'h0088, 0, 0);
    check("b_stall_data", 32'(out_data_b), 32'h0077);
    check("b_stall_count", 32'(count_b), 32'd1);
    cyc_b(0, 0, 1, 0);
    // Clear while delivering: the delivered entry still counts.
    cyc_b(1, 16'h0099, 0, 0);
    cyc_b(0, 0, 1, 1);
    check("b_clr_data", 32'(out_data_b), 32'hDEAD);
    check("b_clr_count", 32'(count_b), 32'd0);
    cyc_b(0, 0, 0, 0);

    check("sb_a_empty", 32'(exp_a.size()), 32'd0);
    check("sb_b_empty", 32'(exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 Parameter BUBBLE, default '0 (WIDTH bits), value driven on out_data whenever out_valid=0.
REQ-003 Parameter SKID, default 1, 1 = two-entry skid buffer with registered in_ready, 0 = single entry with combinational in_ready.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clear  input  1  synchronous flush, bubble insertion.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept; transfer-in = in_valid & in_ready.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream payload valid.
REQ-011 out_ready  input  1  downstream accepts; transfer-out = out_valid & out_ready.
REQ-012 out_data  output  WIDTH  downstream payload, registered.
REQ-013 count  output  2  entries held (0..2; never exceeds 1 when SKID=0).

Function
REQ-014 out_data and out_valid shall come directly from flops (main entry); no combinational path from in_* to out_*.
REQ-015 Latency: an entry accepted at edge N shall appear on out_valid/out_data after edge N when the stage was empty.
REQ-016 Order shall be preserved; no entry duplicated or dropped except by clear/rst.
REQ-017 SKID=1 states: EMPTY (count 0), ONE (main full), FULL (main+skid full).
REQ-018 SKID=1 in_ready shall equal (state != FULL), registered, independent of out_ready in the same cycle.
REQ-019 EMPTY: transfer-in -> ONE, main <= in_data.
REQ-020 ONE: in only -> FULL, skid <= in_data; out only -> EMPTY; in and out -> ONE, main <= in_data.
REQ-021 FULL: in_ready=0; transfer-out -> ONE, main <= skid; otherwise hold.
REQ-022 SKID=0: in_ready = ~out_valid | out_ready; transfer-in loads main (count 1); transfer-out without transfer-in -> count 0.
REQ-023 Stall: while out_valid=1 and out_ready=0, out_data shall be held stable.
REQ-024 clear shall take priority over all transfers: next edge count=0, out_valid=0, out_data=BUBBLE, in_ready=1; in_data offered in the clear cycle shall be discarded; transfer-out in that cycle still counts as delivered.
REQ-025 count shall equal number of valid entries after every edge.
REQ-026 Skid payload register shall be loaded only on FULL entry; its value is don't-care otherwise.

Reset
REQ-027 rst=1 shall immediately, without clk, force out_valid=0, out_data=BUBBLE, count=0, state EMPTY, in_ready=1.
REQ-028 rst asserted mid-operation shall discard all held entries; first edge after deassert behaves as from EMPTY.
REQ-029 No output shall be X after reset for any parameter set.

Verification
REQ-030 WIDTH=32, SKID=1: in_valid=1 data 0xA1 one cycle, out_ready=1 -> out_valid=1 out_data=0xA1 after next edge, then out_valid=0, out_data=0.
REQ-031 SKID=1 back-pressure: out_ready=0, push 0x11,0x22,0x33 on consecutive cycles -> count 1,2,2; in_ready=0 after 2nd push; 0x33 held upstream; release out_ready -> outputs 0x11,0x22,0x33 in order.
REQ-032 Full throughput: in_valid=out_ready=1 for 8 cycles, data 1..8 -> out_data 1..8 on consecutive cycles, count stays 1, in_ready stays 1.
REQ-033 clear with count=2 and in_valid=1 data 0x55 -> next edge out_valid=0, out_data=BUBBLE, count=0, 0x55 never appears.
REQ-034 Async reset mid-stream: assert rst between edges with count=2 -> out_valid=0, count=0 immediately; after deassert push 0x7 -> 0x7 out one edge later.
REQ-035 SKID=0, BUBBLE=0xDEAD, WIDTH=16: out_ready=0 with full stage -> in_ready=0; out_ready=1 same cycle as in_valid data 0x0042 -> in_ready=1, 0x0042 out next edge; idle shows 0xDEAD.
